pipe_field: RTL and testbench



---
 rtl/pipe_field.sv | 116 +++++++++++
 tb/tb_pipe_field.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_field.sv
// Scrolling pipe field for the flappy-bird playfield: LFSR-chosen gaps, periodic
// insertion, left scroll every TICK_DIV running clocks, with scroll and pass pulses.
`timescale 1ns/1ps

module pipe_field #(
    parameter int         COLS      = 16,
    parameter int         ROWS      = 16,
    parameter int         GAP       = 4,
    parameter int         SPACING   = 6,
    parameter int         TICK_DIV  = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      clear,
    output logic [ROWS*COLS-1:0]      field,
    output logic [$clog2(ROWS)-1:0]   next_gap,
    output logic                      scroll_tick,
    output logic                      pipe_passed
);

    localparam int TW        = $clog2(TICK_DIV) + 1;
    localparam int SW        = $clog2(SPACING) + 1;
    localparam int GW        = $clog2(ROWS);
    localparam int FW        = ROWS * COLS;
    localparam int GAP_SLOTS = ROWS - GAP + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SP_LAST   = SW'(SPACING - 1);

    logic [7:0]      lfsr_q, lfsr_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [SW-1:0]   sp_q, sp_d;
    logic [FW-1:0]   field_q, field_d;
    logic            scroll_q, scroll_d;
    logic            passed_q, passed_d;

    logic            step;
    logic            col0_any;
    logic [ROWS-1:0] in_col;
    logic [FW-1:0]   shifted;

    // Taps x^8+x^6+x^5+x^4+1; free-running so the gap sequence never stalls.
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign next_gap = GW'({24'd0, lfsr_q} % 32'(GAP_SLOTS));

    assign step = run && (tick_q == TICK_LAST);

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        in_col   = '0;
        col0_any = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            in_col[r] = (sp_q == '0) &&
                        !((r >= int'(next_gap)) && (r < int'(next_gap) + GAP));
            col0_any  = col0_any | field_q[r*COLS];
        end
    end

    always_comb begin
        shifted = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS - 1; c++) begin
                shifted[r*COLS + c] = field_q[r*COLS + c + 1];
            end
            shifted[r*COLS + COLS - 1] = in_col[r];
        end
    end

    // clear outranks a step and suppresses its pulses.
    always_comb begin
        field_d  = field_q;
        tick_d   = tick_q;
        sp_d     = sp_q;
        scroll_d = 1'b0;
        passed_d = 1'b0;
        if (clear) begin
            field_d = '0;
            tick_d  = '0;
            sp_d    = '0;
        end else if (step) begin
            field_d  = shifted;
            tick_d   = '0;
            sp_d     = (sp_q == SP_LAST) ? '0 : sp_q + SW'(1);
            scroll_d = 1'b1;
            passed_d = col0_any;
        end else if (run) begin
            tick_d = tick_q + TW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q   <= LFSR_SEED;
            tick_q   <= '0;
            sp_q     <= '0;
            field_q  <= '0;
            scroll_q <= 1'b0;
            passed_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            tick_q   <= tick_d;
            sp_q     <= sp_d;
            field_q  <= field_d;
            scroll_q <= scroll_d;
            passed_q <= passed_d;
        end
    end

    assign field       = field_q;
    assign scroll_tick = scroll_q;
    assign pipe_passed = passed_q;

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: column-queue reference model compared every
// cycle, directed scenarios pinned with hand-computed literals, then random run/clear.
`timescale 1ns/1ps

module tb_pipe_field;

    localparam int         COLS     = 16;
    localparam int         ROWS     = 16;
    localparam int         GAP      = 4;
    localparam int         SPACING  = 6;
    localparam int         TICK_DIV = 8;
    localparam logic [7:0] SEED     = 8'hA5;
    localparam int         FW       = ROWS * COLS;
    localparam int         GW       = $clog2(ROWS);

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          run   = 1'b0;
    logic          clear = 1'b0;
    logic [FW-1:0] field;
    logic [GW-1:0] next_gap;
    logic          scroll_tick;
    logic          pipe_passed;

    always #5 clk = ~clk;

    pipe_field #(
        .COLS(COLS), .ROWS(ROWS), .GAP(GAP), .SPACING(SPACING),
        .TICK_DIV(TICK_DIV), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .clear(clear),
        .field(field), .next_gap(next_gap),
        .scroll_tick(scroll_tick), .pipe_passed(pipe_passed)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: column 0 at the queue front, each column a ROWS-bit pattern.
    logic [ROWS-1:0] m_cols[$];
    int              m_lfsr, m_cnt, m_sp;
    bit              m_tick, m_pass;

    function automatic logic [FW-1:0] m_field();
        logic [FW-1:0] v = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                v[r*COLS + c] = m_cols[c][r];
        return v;
    endfunction

    function automatic int m_gap();
        return m_lfsr % (ROWS - GAP + 1);
    endfunction

    function automatic int col_ones(input logic [FW-1:0] f, input int c);
        int n = 0;
        for (int r = 0; r < ROWS; r++) n += int'(f[r*COLS + c]);
        return n;
    endfunction

    task automatic model_reset();
        m_cols.delete();
        for (int c = 0; c < COLS; c++) m_cols.push_back('0);
        m_lfsr = int'(SEED);
        m_cnt  = 0;
        m_sp   = 0;
        m_tick = 0;
        m_pass = 0;
    endtask

    task automatic model_clock(input bit r_run, input bit r_clear);
        logic [ROWS-1:0] inc;
        int              g;
        m_tick = 0;
        m_pass = 0;
        if (r_clear) begin
            for (int c = 0; c < COLS; c++) m_cols[c] = '0;
            m_cnt = 0;
            m_sp  = 0;
        end else if (r_run) begin
            if (m_cnt == TICK_DIV - 1) begin
                g   = m_gap();
                inc = '1;
                for (int k = 0; k < GAP; k++) inc[g + k] = 1'b0;
                if (m_sp != 0) inc = '0;
                m_pass = (m_cols[0] != '0);
                void'(m_cols.pop_front());
                m_cols.push_back(inc);
                m_sp   = (m_sp + 1) % SPACING;
                m_cnt  = 0;
                m_tick = 1;
            end else begin
                m_cnt++;
            end
        end
        m_lfsr = ((m_lfsr << 1) & 255) |
                 (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
    endtask

    task automatic compare_all();
        check("field", field, m_field());
        check("next_gap", FW'(next_gap), FW'(m_gap()));
        check("scroll_tick", FW'(scroll_tick), FW'(m_tick));
        check("pipe_passed", FW'(pipe_passed), FW'(m_pass));
    endtask

    // Called just after a falling edge; drives, clocks the model, checks on the next fall.
    task automatic cycle(input bit r_run, input bit r_clear);
        run   = r_run;
        clear = r_clear;
        @(posedge clk);
        cyc++;
        model_clock(r_run, r_clear);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        run   = 1'b0;
        clear = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        compare_all();
    endtask

    logic [FW-1:0] snap;
    int            first_pass, n_passes, zero_ones;

    initial begin
        // Reset defaults
        do_reset();
        check("reset_gap_literal", FW'(next_gap), FW'(9));
        check("reset_field_literal", field, '0);

        // First step after 8 run cycles: one pipe in column 15
        for (int i = 0; i < TICK_DIV - 1; i++) cycle(1'b1, 1'b0);
        check("no_tick_before_8", FW'(scroll_tick), FW'(0));
        cycle(1'b1, 1'b0);
        check("first_tick_literal", FW'(scroll_tick), FW'(1));
        check("first_pipe_col15", FW'(col_ones(field, 15)), FW'(12));
        check("first_pipe_total", FW'($countones(field)), FW'(12));

        // After 6 steps the pipe is at column 10; step 7 inserts the next pipe
        for (int i = 0; i < 5 * TICK_DIV; i++) cycle(1'b1, 1'b0);
        check("pipe_at_col10", FW'(col_ones(field, 10)), FW'(12));
        for (int i = 0; i < TICK_DIV; i++) cycle(1'b1, 1'b0);
        check("second_pipe_col15", FW'(col_ones(field, 15)), FW'(12));
        zero_ones = 0;
        for (int c = 11; c < 15; c++) zero_ones += col_ones(field, c);
        check("spacing_cols_11_14", FW'(zero_ones), FW'(0));
        check("two_pipes_total", FW'($countones(field)), FW'(24));

        // Pause with the counter at 6, then two run cycles produce the step
        for (int i = 0; i < TICK_DIV + 1 && m_cnt != 6; i++) cycle(1'b1, 1'b0);
        snap = field;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        check("pause_field_frozen", field, snap);
        cycle(1'b1, 1'b0);
        check("resume_no_tick_yet", FW'(scroll_tick), FW'(0));
        cycle(1'b1, 1'b0);
        check("resume_tick_after_2", FW'(scroll_tick), FW'(1));

        // Pass detection from a fresh reset with run held high
        do_reset();
        first_pass = 0;
        n_passes   = 0;
        for (int i = 1; i <= 140; i++) begin
            cycle(1'b1, 1'b0);
            if (pipe_passed) begin
                n_passes++;
                if (first_pass == 0) begin
                    first_pass = i;
                    check("pass_with_tick", FW'(scroll_tick), FW'(1));
                end
            end
        end
        check("first_pass_clock", FW'(first_pass), FW'(136));
        check("pass_count_140", FW'(n_passes), FW'(1));

        // clear in a step cycle suppresses the step; next step inserts a pipe
        for (int i = 0; i < TICK_DIV + 1 && m_cnt != TICK_DIV - 1; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("clear_field_literal", field, '0);
        check("clear_no_tick", FW'(scroll_tick), FW'(0));
        for (int i = 0; i < TICK_DIV - 1; i++) cycle(1'b1, 1'b0);
        check("clear_no_early_tick", FW'(scroll_tick), FW'(0));
        cycle(1'b1, 1'b0);
        check("clear_then_tick", FW'(scroll_tick), FW'(1));
        check("clear_then_pipe", FW'(col_ones(field, 15)), FW'(12));

        // Asynchronous reset between clock edges
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_field", field, '0);
        check("async_rst_gap", FW'(next_gap), FW'(9));
        check("async_rst_tick", FW'(scroll_tick), FW'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Random run/clear traffic against the model
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 8) != 0, ($urandom % 64) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
